// File: rtl/opb_counter_bank.sv
// Bank of N_CH event counters with atomic snapshot shadows, sticky overflow flags and
// software clear/saturate control, exposed as an OPB slave register window.

module opb_counter_bank_lane #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ev,
    input  logic                 sat,
    input  logic                 snap,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [CNT_WIDTH-1:0] shadow,
    output logic                 ovf_set
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
    logic                 at_max;

    always_comb begin
        at_max   = &cnt_q;
        // shadow always takes the pre-increment, pre-clear value
        shadow_d = snap ? cnt_q : shadow_q;
        cnt_d    = cnt_q;
        ovf_set  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (ev) begin
            if (at_max) begin
                cnt_d   = sat ? cnt_q : '0;
                ovf_set = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt    = cnt_q;
    assign shadow = shadow_q;
endmodule

module opb_counter_bank #(
    parameter logic [31:0] C_BASEADDR   = 32'h01080200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010802FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [N_CH-1:0]         event_in,
    input  logic                    cnt_en,
    input  logic                    snap_in,
    output logic                    ovf_any
);
    // OPB bit 0 is the MSB; plain assignment to [31:0] gives conventional numbering.
    logic [31:0] abus, wdata, off, rdata;
    logic        hit;

    logic        ack_q, ack_d, rnw_q, rnw_d, be_ok_q, be_ok_d;
    logic [29:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sat_q, sat_d, ovf_any_q, ovf_any_d;
    logic [N_CH-1:0] ovf_q, ovf_d, ovf_set, w1c_mask, ev;

    logic [N_CH-1:0][CNT_WIDTH-1:0] cnt, shadow;
    logic fire, ctrl_wr, stat_wr, snap, clr;

    assign abus  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign off   = abus - C_BASEADDR;
    assign hit   = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    always_comb begin
        // never ack on back-to-back cycles; request is latched on the hit edge
        ack_d   = hit && !ack_q;
        rnw_d   = ack_d ? OPB_RNW : rnw_q;
        be_ok_d = ack_d ? (OPB_BE == 4'b1111) : be_ok_q;
        word_d  = ack_d ? off[31:2] : word_q;
        wdata_d = ack_d ? wdata : wdata_q;

        fire     = ack_q && !rnw_q && be_ok_q;
        ctrl_wr  = fire && (word_q == 30'd0);
        stat_wr  = fire && (word_q == 30'd1);
        snap     = snap_in || (ctrl_wr && wdata_q[0]);
        clr      = ctrl_wr && wdata_q[1];
        sat_d    = ctrl_wr ? wdata_q[2] : sat_q;
        w1c_mask = stat_wr ? wdata_q[N_CH-1:0] : '0;
        ovf_d    = (ovf_q & ~w1c_mask) | ovf_set;
        ovf_any_d = |ovf_q;
        ev       = event_in & {N_CH{cnt_en}};
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        opb_counter_bank_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
            .clk    (OPB_Clk),
            .rst_n  (OPB_Rst_n),
            .ev     (ev[i]),
            .sat    (sat_q),
            .snap   (snap),
            .clr    (clr),
            .cnt    (cnt[i]),
            .shadow (shadow[i]),
            .ovf_set(ovf_set[i])
        );
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_q     <= 1'b0;
            rnw_q     <= 1'b0;
            be_ok_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= '0;
            ovf_any_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            rnw_q     <= rnw_d;
            be_ok_q   <= be_ok_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
            ovf_any_q <= ovf_any_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (word_q == 30'd0) begin
            rdata[2] = sat_q;
        end else if (word_q == 30'd1) begin
            rdata[N_CH-1:0] = ovf_q;
        end else begin
            for (int k = 0; k < int'(N_CH); k++) begin
                if (word_q == 30'(k + 2)) rdata[CNT_WIDTH-1:0] = shadow[k];
            end
        end
    end

    assign Sl_DBus    = (ack_q && rnw_q) ? rdata : '0;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign ovf_any    = ovf_any_q;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, off[1:0], wdata_q, cnt};
endmodule
